// File: rtl/deci_filter_dma_sm_mc_if.sv
// Channel-side and system-DMA-side signals of the multi-channel decimation DMA request controller.
// The master modport is the controller's view; slave is the surrounding fabric / system DMA.
interface deci_filter_dma_sm_mc_if #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 9,
   parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
   logic [NUM_CH-1:0]       DMA_Start_i;
   logic [NUM_CH*CNT_W-1:0] DMA_CNT_i;
   logic [NUM_CH-1:0]       RXFIFO_Pop_i;
   logic                    DMA_Active_i;
   logic                    DMA_REQ_o;
   logic                    DMA_Active_o;
   logic [NUM_CH-1:0]       DMA_Grant_o;
   logic                    DMA_Clr_o;
   logic [NUM_CH-1:0]       DMA_DONE_o;
   logic                    DMA_Busy_o;
   logic [CH_W-1:0]         dma_ch_o;
   logic [CNT_W-1:0]        dma_cntr_o;
   logic [1:0]              dma_st_o;

   modport master (
      input  DMA_Start_i, DMA_CNT_i, RXFIFO_Pop_i, DMA_Active_i,
      output DMA_REQ_o, DMA_Active_o, DMA_Grant_o, DMA_Clr_o, DMA_DONE_o,
             DMA_Busy_o, dma_ch_o, dma_cntr_o, dma_st_o
   );

   modport slave (
      output DMA_Start_i, DMA_CNT_i, RXFIFO_Pop_i, DMA_Active_i,
      input  DMA_REQ_o, DMA_Active_o, DMA_Grant_o, DMA_Clr_o, DMA_DONE_o,
             DMA_Busy_o, dma_ch_o, dma_cntr_o, dma_st_o
   );
endinterface

// File: rtl/deci_filter_dma_sm_mc.sv
// Round-robin DMA request controller: shares one system DMA REQ/ACTIVE handshake between
// NUM_CH decimation/I2S receive channels and counts FIFO pops against each channel's terminal count.
module deci_filter_dma_sm_mc #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned CNT_W  = 9
) (
   input  logic                    WBs_CLK_i,
   input  logic                    WBs_RST_i,
   input  logic                    EN_i,
   deci_filter_dma_sm_mc_if.master dma_if
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_XFR   = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e             state_q,  state_d;
   logic               req_q,    req_d;
   logic               clr_q,    clr_d;
   logic               busy_q,   busy_d;
   logic [NUM_CH-1:0]  grant_q,  grant_d;
   logic [NUM_CH-1:0]  done_q,   done_d;
   logic [CH_W-1:0]    ch_q,     ch_d;
   logic [CH_W-1:0]    ptr_q,    ptr_d;
   logic [CNT_W-1:0]   cntr_q,   cntr_d;
   logic               act_s1_q, act_s1_d;
   logic               act_s2_q, act_s2_d;

   logic               arb_found;
   logic [CH_W-1:0]    arb_idx;
   logic [CH_W-1:0]    arb_cand;
   logic [CNT_W-1:0]   term_cnt;
   logic               pop_sel;
   logic               start_sel;

   // Round-robin search: first requesting channel strictly after the last one granted.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_cand  = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         arb_cand = CH_W'((32'(ptr_q) + i) % NUM_CH);
         if (!arb_found && dma_if.DMA_Start_i[arb_cand]) begin
            arb_found = 1'b1;
            arb_idx   = arb_cand;
         end
      end
   end

   // Live view of the granted channel's inputs.
   always_comb begin
      term_cnt  = dma_if.DMA_CNT_i[32'(ch_q) * CNT_W +: CNT_W];
      pop_sel   = dma_if.RXFIFO_Pop_i[ch_q];
      start_sel = dma_if.DMA_Start_i[ch_q];
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      clr_d    = 1'b0;
      busy_d   = busy_q;
      grant_d  = grant_q;
      done_d   = '0;
      ch_d     = ch_q;
      ptr_d    = ptr_q;
      cntr_d   = cntr_q;
      act_s1_d = dma_if.DMA_Active_i;
      act_s2_d = act_s1_q;

      case (state_q)
         ST_IDLE: begin
            cntr_d = '0;
            if (arb_found) begin
               state_d = ST_START;
               req_d   = 1'b1;
               busy_d  = 1'b1;
               grant_d = NUM_CH'(1) << arb_idx;
               ch_d    = arb_idx;
               ptr_d   = arb_idx;
            end
         end
         ST_START: begin
            // A withdrawn request wins over a coincident ACTIVE.
            if (!start_sel) begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               busy_d  = 1'b0;
               grant_d = '0;
               ch_d    = '0;
            end else if (act_s2_q) begin
               state_d = ST_XFR;
               req_d   = 1'b0;
               clr_d   = 1'b1;
            end
         end
         ST_XFR: begin
            if (pop_sel) begin
               cntr_d = cntr_q + CNT_W'(1);
            end
            if (cntr_q == term_cnt) begin
               state_d = ST_DONE;
               done_d  = grant_q;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            grant_d = '0;
            ch_d    = '0;
            cntr_d  = '0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Disable behaves as a synchronous reset of every flop.
      if (!EN_i) begin
         state_d  = ST_IDLE;
         req_d    = 1'b0;
         clr_d    = 1'b0;
         busy_d   = 1'b0;
         grant_d  = '0;
         done_d   = '0;
         ch_d     = '0;
         ptr_d    = CH_W'(NUM_CH - 1);
         cntr_d   = '0;
         act_s1_d = 1'b0;
         act_s2_d = 1'b0;
      end
   end

   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         clr_q    <= 1'b0;
         busy_q   <= 1'b0;
         grant_q  <= '0;
         done_q   <= '0;
         ch_q     <= '0;
         ptr_q    <= CH_W'(NUM_CH - 1);
         cntr_q   <= '0;
         act_s1_q <= 1'b0;
         act_s2_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         clr_q    <= clr_d;
         busy_q   <= busy_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         ch_q     <= ch_d;
         ptr_q    <= ptr_d;
         cntr_q   <= cntr_d;
         act_s1_q <= act_s1_d;
         act_s2_q <= act_s2_d;
      end
   end

   assign dma_if.DMA_REQ_o    = req_q;
   assign dma_if.DMA_Active_o = act_s2_q;
   assign dma_if.DMA_Grant_o  = grant_q;
   assign dma_if.DMA_Clr_o    = clr_q;
   assign dma_if.DMA_DONE_o   = done_q;
   assign dma_if.DMA_Busy_o   = busy_q;
   assign dma_if.dma_ch_o     = ch_q;
   assign dma_if.dma_cntr_o   = cntr_q;
   assign dma_if.dma_st_o     = state_q;
endmodule

// File: tb/tb_deci_filter_dma_sm_mc.sv
// Bench for deci_filter_dma_sm_mc: directed transfers with a done-pulse scoreboard.
module tb_deci_filter_dma_sm_mc;
   localparam int unsigned NUM_CH = 2;
   localparam int unsigned CNT_W  = 9;

   localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_XFR = 2'd2, S_DONE = 2'd3;

   logic clk = 1'b0;
   logic rst;
   logic en;

   always #5 clk = ~clk;

   deci_filter_dma_sm_mc_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

   deci_filter_dma_sm_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .WBs_CLK_i (clk),
      .WBs_RST_i (rst),
      .EN_i      (en),
      .dma_if    (bus)
   );

   typedef struct packed {
      logic [NUM_CH-1:0] done;
      logic [0:0]        ch;
      logic [CNT_W-1:0]  cntr;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int c, input int cntr_at_done);
      exp_t e;
      e.done = NUM_CH'(1) << c;
      e.ch   = 1'(c);
      e.cntr = CNT_W'(cntr_at_done);
      sb.push_back(e);
   endtask

   task automatic set_cnt(input int c, input int v);
      bus.DMA_CNT_i[c*CNT_W +: CNT_W] = CNT_W'(v);
   endtask

   task automatic pop_n(input int c, input int n);
      bus.RXFIFO_Pop_i[c] = 1'b1;
      step(n);
      bus.RXFIFO_Pop_i[c] = 1'b0;
   endtask

   task automatic wait_st(input string tag, input logic [1:0] st, input int budget);
      for (int i = 0; i < budget && bus.dma_st_o !== st; i++) step(1);
      check_val(tag, 32'(bus.dma_st_o), 32'(st));
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_st"},    32'(bus.dma_st_o),     0);
      check_val({tag, "_req"},   32'(bus.DMA_REQ_o),    0);
      check_val({tag, "_busy"},  32'(bus.DMA_Busy_o),   0);
      check_val({tag, "_grant"}, 32'(bus.DMA_Grant_o),  0);
      check_val({tag, "_cntr"},  32'(bus.dma_cntr_o),   0);
      check_val({tag, "_act"},   32'(bus.DMA_Active_o), 0);
      check_val({tag, "_ch"},    32'(bus.dma_ch_o),     0);
      check_val({tag, "_clr"},   32'(bus.DMA_Clr_o),    0);
      check_val({tag, "_done"},  32'(bus.DMA_DONE_o),   0);
   endtask

   // Every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin : done_mon
      exp_t e;
      if (bus.DMA_DONE_o !== '0) begin
         check_val("done_expected", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_val("done_vec",  32'(bus.DMA_DONE_o), 32'(e.done));
            check_val("done_ch",   32'(bus.dma_ch_o),   32'(e.ch));
            check_val("done_cntr", 32'(bus.dma_cntr_o), 32'(e.cntr));
            check_val("done_busy", 32'(bus.DMA_Busy_o), 1);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      en  = 1'b1;
      bus.DMA_Start_i  = '0;
      bus.DMA_CNT_i    = '0;
      bus.RXFIFO_Pop_i = '0;
      bus.DMA_Active_i = 1'b0;
      step(3);
      check_all_zero("rst");
      rst = 1'b0;
      step(2);

      // ch0, terminal count 4, ACTIVE three cycles after the request
      set_cnt(0, 4);
      bus.DMA_Start_i[0] = 1'b1;
      step(1);
      check_val("t1_st",    32'(bus.dma_st_o),    32'(S_START));
      check_val("t1_req",   32'(bus.DMA_REQ_o),   1);
      check_val("t1_busy",  32'(bus.DMA_Busy_o),  1);
      check_val("t1_grant", 32'(bus.DMA_Grant_o), 1);
      check_val("t1_ch",    32'(bus.dma_ch_o),    0);
      push_exp(0, 4);
      step(3);
      bus.DMA_Active_i = 1'b1;
      step(1);
      check_val("t1_act_n",   32'(bus.DMA_Active_o), 0);
      step(1);
      check_val("t1_act_n1",  32'(bus.DMA_Active_o), 1);
      check_val("t1_st_n1",   32'(bus.dma_st_o),     32'(S_START));
      check_val("t1_req_n1",  32'(bus.DMA_REQ_o),    1);
      step(1);
      check_val("t1_st_n2",   32'(bus.dma_st_o),     32'(S_XFR));
      check_val("t1_clr_n2",  32'(bus.DMA_Clr_o),    1);
      check_val("t1_req_n2",  32'(bus.DMA_REQ_o),    0);
      bus.RXFIFO_Pop_i[0] = 1'b1;
      step(1);
      check_val("t1_clr_n3",  32'(bus.DMA_Clr_o),    0);
      check_val("t1_cntr1",   32'(bus.dma_cntr_o),   1);
      step(3);
      bus.RXFIFO_Pop_i[0] = 1'b0;
      check_val("t1_cntr4",   32'(bus.dma_cntr_o),   4);
      check_val("t1_st_m",    32'(bus.dma_st_o),     32'(S_XFR));
      step(1);
      check_val("t1_st_m1",   32'(bus.dma_st_o),     32'(S_DONE));
      check_val("t1_done_m1", 32'(bus.DMA_DONE_o),   1);
      bus.DMA_Start_i[0] = 1'b0;
      bus.DMA_Active_i   = 1'b0;
      step(1);
      check_val("t1_st_m2",   32'(bus.dma_st_o),     32'(S_IDLE));
      check_val("t1_busy_m2", 32'(bus.DMA_Busy_o),   0);
      check_val("t1_done_m2", 32'(bus.DMA_DONE_o),   0);
      check_val("t1_grant_m2",32'(bus.DMA_Grant_o),  0);
      step(3);

      // ch0 in XFR while only ch1 pops
      set_cnt(0, 2);
      bus.DMA_Start_i[0] = 1'b1;
      bus.DMA_Active_i   = 1'b1;
      wait_st("t2_xfr", S_XFR, 10);
      bus.DMA_Start_i[0] = 1'b0;
      bus.RXFIFO_Pop_i[1] = 1'b1;
      step(20);
      bus.RXFIFO_Pop_i[1] = 1'b0;
      check_val("t2_cntr", 32'(bus.dma_cntr_o), 0);
      check_val("t2_st",   32'(bus.dma_st_o),   32'(S_XFR));
      push_exp(0, 2);
      pop_n(0, 2);
      wait_st("t2_idle", S_IDLE, 10);
      bus.DMA_Active_i = 1'b0;
      step(3);

      // request withdrawn in START; pointer still advances to ch1
      bus.DMA_Start_i[1] = 1'b1;
      step(1);
      check_val("t3_st",    32'(bus.dma_st_o),    32'(S_START));
      check_val("t3_grant", 32'(bus.DMA_Grant_o), 2);
      check_val("t3_ch",    32'(bus.dma_ch_o),    1);
      bus.DMA_Start_i[1] = 1'b0;
      step(1);
      check_val("t3_abort_st",    32'(bus.dma_st_o),    32'(S_IDLE));
      check_val("t3_abort_req",   32'(bus.DMA_REQ_o),   0);
      check_val("t3_abort_busy",  32'(bus.DMA_Busy_o),  0);
      check_val("t3_abort_grant", 32'(bus.DMA_Grant_o), 0);
      bus.DMA_Start_i = 2'b11;
      step(1);
      check_val("t3_ptr_adv", 32'(bus.DMA_Grant_o), 1);
      bus.DMA_Start_i = 2'b00;
      step(1);
      check_val("t3_abort2_st", 32'(bus.dma_st_o), 32'(S_IDLE));

      // disable in the middle of a ch1 transfer
      set_cnt(1, 6);
      bus.DMA_Start_i[1] = 1'b1;
      bus.DMA_Active_i   = 1'b1;
      wait_st("t4_xfr", S_XFR, 10);
      bus.DMA_Start_i[1] = 1'b0;
      pop_n(1, 2);
      check_val("t4_cntr", 32'(bus.dma_cntr_o), 2);
      en = 1'b0;
      step(1);
      check_all_zero("t4_en");

      // re-enable with both channels requesting: ch0, ch1, ch0
      en = 1'b1;
      set_cnt(0, 3);
      set_cnt(1, 5);
      bus.DMA_Start_i = 2'b11;
      for (int k = 0; k < 3; k++) begin
         int c;
         int n;
         c = k % 2;
         n = (c == 0) ? 3 : 5;
         for (int i = 0; i < 10 && bus.DMA_Grant_o == '0; i++) step(1);
         check_val($sformatf("t5_grant%0d", k), 32'(bus.DMA_Grant_o), 32'(1 << c));
         wait_st($sformatf("t5_xfr%0d", k), S_XFR, 10);
         push_exp(c, n);
         pop_n(c, n);
         wait_st($sformatf("t5_idle%0d", k), S_IDLE, 10);
      end
      bus.DMA_Start_i  = 2'b00;
      bus.DMA_Active_i = 1'b0;
      step(3);

      // terminal count 0 completes on the first XFR cycle
      set_cnt(0, 0);
      bus.DMA_Start_i[0] = 1'b1;
      bus.DMA_Active_i   = 1'b1;
      wait_st("t6_xfr", S_XFR, 10);
      bus.DMA_Start_i[0] = 1'b0;
      check_val("t6_cntr", 32'(bus.dma_cntr_o), 0);
      push_exp(0, 0);
      step(1);
      check_val("t6_st_done", 32'(bus.dma_st_o),   32'(S_DONE));
      check_val("t6_done",    32'(bus.DMA_DONE_o), 1);
      step(1);
      check_val("t6_st_idle", 32'(bus.dma_st_o),   32'(S_IDLE));

      // terminal count 511 with 512 back-to-back pops
      set_cnt(1, 511);
      bus.DMA_Start_i[1] = 1'b1;
      wait_st("t7_xfr", S_XFR, 10);
      bus.DMA_Start_i[1] = 1'b0;
      push_exp(1, 0);
      bus.RXFIFO_Pop_i[1] = 1'b1;
      step(511);
      check_val("t7_cntr511", 32'(bus.dma_cntr_o), 511);
      check_val("t7_st_xfr",  32'(bus.dma_st_o),   32'(S_XFR));
      check_val("t7_nodone",  32'(bus.DMA_DONE_o), 0);
      step(1);
      bus.RXFIFO_Pop_i[1] = 1'b0;
      check_val("t7_st_done", 32'(bus.dma_st_o),   32'(S_DONE));
      check_val("t7_done",    32'(bus.DMA_DONE_o), 2);
      check_val("t7_wrap",    32'(bus.dma_cntr_o), 0);
      step(1);
      check_val("t7_st_idle", 32'(bus.dma_st_o),   32'(S_IDLE));
      bus.DMA_Active_i = 1'b0;
      step(3);

      // asynchronous reset while in START clears outputs without a clock edge
      bus.DMA_Start_i[0] = 1'b1;
      step(1);
      check_val("t8_st", 32'(bus.dma_st_o), 32'(S_START));
      #2;
      rst = 1'b1;
      #1;
      check_val("t8_rst_st",    32'(bus.dma_st_o),    0);
      check_val("t8_rst_req",   32'(bus.DMA_REQ_o),   0);
      check_val("t8_rst_busy",  32'(bus.DMA_Busy_o),  0);
      check_val("t8_rst_grant", 32'(bus.DMA_Grant_o), 0);
      bus.DMA_Start_i = 2'b00;
      step(2);
      rst = 1'b0;
      step(2);

      check_val("sb_drained", 32'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
